// File: rtl/weight_buffer_pkg.sv
// Shared definitions for the ping-pong weight buffer: geometry helpers,
// fill state encoding and the signed saturation helper used when the
// WEIGHT_BUFFER_SAT_EN build option is defined.
package weight_buffer_pkg;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_FILL = 2'd1,
        FILL_WAIT = 2'd2
    } fill_state_e;

    // Number of weights in one kernel.
    function automatic int unsigned ksize(input int unsigned h, input int unsigned w);
        return h * w;
    endfunction

    // Number of words needed to fill one bank.
    function automatic int unsigned total_words(input int unsigned nk,
                                                input int unsigned h,
                                                input int unsigned w);
        return nk * h * w;
    endfunction

    // Width of a counter that must hold 0..total inclusive.
    function automatic int unsigned count_width(input int unsigned total);
        return $clog2(total + 32'd1);
    endfunction

    // Width of an index selecting one of n items (at least one bit).
    function automatic int unsigned index_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

    // Clamp a signed 32-bit word to the signed range of a w-bit field.
    function automatic logic [31:0] saturate(input logic [31:0] d, input int unsigned w);
        logic signed [31:0] d_s;
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        d_s   = $signed(d);
        max_v = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        min_v = -(32'sd1 <<< (w - 32'd1));
        if (d_s > max_v) begin
            return max_v;
        end else if (d_s < min_v) begin
            return min_v;
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/weight_bank.sv
// One storage bank: NUM_KERNELS kernels of KSIZE weights, single write port
// addressed by (kernel, position) and a combinational kernel read mux.
// Storage is intentionally not reset; validity is tracked by the top level.
module weight_bank
    import weight_buffer_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned KSIZE       = 9,
    parameter int unsigned NUM_KERNELS = 4
) (
    input  logic                                  clk,
    input  logic                                  wr_en,
    input  logic [index_width(NUM_KERNELS)-1:0]   wr_kernel,
    input  logic [index_width(KSIZE)-1:0]         wr_pos,
    input  logic [WIDTH-1:0]                      wr_data,
    input  logic [index_width(NUM_KERNELS)-1:0]   rd_kernel,
    output logic [KSIZE*WIDTH-1:0]                rd_data
);

    localparam int unsigned KW = index_width(NUM_KERNELS);
    localparam int unsigned PW = index_width(KSIZE);

    logic [KSIZE*WIDTH-1:0] mem_r [NUM_KERNELS];

    // Write one weight into its kernel slot; position 0 is the LSB slice.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NUM_KERNELS); k++) begin
            for (int p = 0; p < int'(KSIZE); p++) begin
                if (wr_en && (wr_kernel == KW'(k)) && (wr_pos == PW'(p))) begin
                    mem_r[k][p*WIDTH +: WIDTH] <= wr_data;
                end
            end
        end
    end

    // Select the requested kernel; out-of-range indices read as zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < int'(NUM_KERNELS); k++) begin
            if (rd_kernel == KW'(k)) begin
                rd_data = mem_r[k];
            end else begin
                rd_data = rd_data;
            end
        end
    end

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Ping-pong weight store: one bank is filled word-by-word from the AXI side
// while the other is presented to the consumer. A completed fill swaps in
// immediately when the presented bank is free (or released in the same
// cycle), otherwise it waits with data_ready low until the next release.
// Build option WEIGHT_BUFFER_SAT_EN: saturate signed input words to WIDTH
// bits instead of truncating them.
module weight_pingpong_buffer
    import weight_buffer_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned WEIGHT_HEIGHT = 3,
    parameter int unsigned WEIGHT_WIDTH  = 3,
    parameter int unsigned NUM_KERNELS   = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [31:0]                                 data_in,
    input  logic                                        data_valid,
    output logic                                        data_ready,
    input  logic                                        clear,
    input  logic [index_width(NUM_KERNELS)-1:0]         kernel_index,
    input  logic                                        weights_release,
    output logic                                        weights_valid,
    output logic                                        active_bank,
    output logic [count_width(total_words(NUM_KERNELS, WEIGHT_HEIGHT, WEIGHT_WIDTH))-1:0] fill_count,
    output logic [WIDTH*WEIGHT_HEIGHT*WEIGHT_WIDTH-1:0] weights
);

    localparam int unsigned KSIZE = ksize(WEIGHT_HEIGHT, WEIGHT_WIDTH);
    localparam int unsigned TOTAL = total_words(NUM_KERNELS, WEIGHT_HEIGHT, WEIGHT_WIDTH);
    localparam int unsigned KW    = index_width(NUM_KERNELS);
    localparam int unsigned PW    = index_width(KSIZE);
    localparam int unsigned CW    = count_width(TOTAL);
    localparam int unsigned KBITS = KSIZE * WIDTH;

    fill_state_e      state_r;
    fill_state_e      state_next_s;
    logic [CW-1:0]    fill_count_r;
    logic [KW-1:0]    wr_kernel_r;
    logic [PW-1:0]    wr_pos_r;
    logic             active_bank_r;
    logic             fill_bank_r;
    logic             weights_valid_r;
    logic             accept_s;
    logic             last_s;
    logic             swap_s;
    logic             free_s;
    logic [WIDTH-1:0] wr_data_s;
    logic [1:0]       wr_en_s;
    logic [KBITS-1:0] rd_data0_s;
    logic [KBITS-1:0] rd_data1_s;

    assign data_ready    = (state_r != FILL_WAIT);
    assign accept_s      = data_valid && data_ready;
    assign last_s        = (fill_count_r == CW'(TOTAL - 1));
    assign weights_valid = weights_valid_r;
    assign active_bank   = active_bank_r;
    assign fill_count    = fill_count_r;

`ifdef WEIGHT_BUFFER_SAT_EN
    logic [31:0] sat_word_s;
    logic        sat_unused_s;
    assign sat_word_s   = saturate(data_in, WIDTH);
    assign wr_data_s    = sat_word_s[WIDTH-1:0];
    assign sat_unused_s = ^sat_word_s[31:WIDTH];
`else
    logic        data_unused_s;
    assign wr_data_s     = data_in[WIDTH-1:0];
    assign data_unused_s = ^data_in[31:WIDTH];
`endif

    // A cleared cycle writes nothing; otherwise the accepted word goes to the fill bank.
    always_comb begin
        wr_en_s    = 2'b00;
        wr_en_s[0] = accept_s && !clear && !fill_bank_r;
        wr_en_s[1] = accept_s && !clear && fill_bank_r;
    end

    // Fill state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FILL_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next fill state plus swap / free decisions; clear overrides everything.
    always_comb begin
        state_next_s = state_r;
        swap_s       = 1'b0;
        if (clear) begin
            state_next_s = FILL_IDLE;
        end else begin
            case (state_r)
                FILL_IDLE, FILL_FILL: begin
                    if (accept_s) begin
                        if (last_s) begin
                            if (!weights_valid_r || weights_release) begin
                                swap_s       = 1'b1;
                                state_next_s = FILL_IDLE;
                            end else begin
                                state_next_s = FILL_WAIT;
                            end
                        end else begin
                            state_next_s = FILL_FILL;
                        end
                    end else begin
                        state_next_s = state_r;
                    end
                end
                FILL_WAIT: begin
                    if (weights_release) begin
                        swap_s       = 1'b1;
                        state_next_s = FILL_IDLE;
                    end else begin
                        state_next_s = FILL_WAIT;
                    end
                end
                default: begin
                    state_next_s = FILL_IDLE;
                end
            endcase
        end
        free_s = weights_release && weights_valid_r && !swap_s && !clear;
    end

    // Fill counters, bank roles and presented-bank validity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_count_r    <= '0;
            wr_kernel_r     <= '0;
            wr_pos_r        <= '0;
            active_bank_r   <= 1'b0;
            fill_bank_r     <= 1'b0;
            weights_valid_r <= 1'b0;
        end else if (clear) begin
            fill_count_r    <= '0;
            wr_kernel_r     <= '0;
            wr_pos_r        <= '0;
            fill_bank_r     <= ~active_bank_r;
            weights_valid_r <= 1'b0;
        end else if (swap_s) begin
            fill_count_r    <= '0;
            wr_kernel_r     <= '0;
            wr_pos_r        <= '0;
            active_bank_r   <= fill_bank_r;
            fill_bank_r     <= ~fill_bank_r;
            weights_valid_r <= 1'b1;
        end else begin
            if (accept_s) begin
                fill_count_r <= fill_count_r + CW'(1);
                if (wr_pos_r == PW'(KSIZE - 1)) begin
                    wr_pos_r    <= '0;
                    wr_kernel_r <= wr_kernel_r + KW'(1);
                end else begin
                    wr_pos_r <= wr_pos_r + PW'(1);
                end
            end
            if (free_s) begin
                weights_valid_r <= 1'b0;
            end
        end
    end

    weight_bank #(
        .WIDTH       (WIDTH),
        .KSIZE       (KSIZE),
        .NUM_KERNELS (NUM_KERNELS)
    ) u_bank0 (
        .clk       (clk),
        .wr_en     (wr_en_s[0]),
        .wr_kernel (wr_kernel_r),
        .wr_pos    (wr_pos_r),
        .wr_data   (wr_data_s),
        .rd_kernel (kernel_index),
        .rd_data   (rd_data0_s)
    );

    weight_bank #(
        .WIDTH       (WIDTH),
        .KSIZE       (KSIZE),
        .NUM_KERNELS (NUM_KERNELS)
    ) u_bank1 (
        .clk       (clk),
        .wr_en     (wr_en_s[1]),
        .wr_kernel (wr_kernel_r),
        .wr_pos    (wr_pos_r),
        .wr_data   (wr_data_s),
        .rd_kernel (kernel_index),
        .rd_data   (rd_data1_s)
    );

    // Present the active bank's kernel, gated to zero while no valid set is held.
    always_comb begin
        weights = '0;
        if (weights_valid_r) begin
            weights = active_bank_r ? rd_data1_s : rd_data0_s;
        end else begin
            weights = '0;
        end
    end

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Scenario bench for weight_pingpong_buffer (WIDTH=4, 3x3, NUM_KERNELS=2).
// Expected kernels are pushed to a queue as words are driven and popped when
// the buffer presents them.
module tb_weight_pingpong_buffer;

    localparam int WIDTH = 4;
    localparam int NK    = 2;
    localparam int KSIZE = 9;
    localparam int TOTAL = 18;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        clear = 1'b0;
    logic [0:0]  kernel_index = 1'b0;
    logic        weights_release = 1'b0;
    logic        weights_valid;
    logic        active_bank;
    logic [4:0]  fill_count;
    logic [35:0] weights;

    int checks = 0;
    int errors = 0;

    logic [35:0] model_mem [2][NK];
    logic        model_fill = 1'b0;
    logic [35:0] exp_q [$];

    weight_pingpong_buffer #(
        .WIDTH         (4),
        .WEIGHT_HEIGHT (3),
        .WEIGHT_WIDTH  (3),
        .NUM_KERNELS   (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .data_in         (data_in),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .clear           (clear),
        .kernel_index    (kernel_index),
        .weights_release (weights_release),
        .weights_valid   (weights_valid),
        .active_bank     (active_bank),
        .fill_count      (fill_count),
        .weights         (weights)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one word (optionally with a release in the same cycle) and record it in the model.
    task automatic load_word(input int n, input logic [31:0] d, input logic [3:0] nib, input logic rel);
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_word%0d: got %b expected 1", n, data_ready);
        end
        model_mem[model_fill][n / KSIZE][(n % KSIZE)*WIDTH +: WIDTH] = nib;
        data_in         = d;
        data_valid      = 1'b1;
        weights_release = rel;
        @(posedge clk);
        #1;
        data_valid      = 1'b0;
        weights_release = 1'b0;
    endtask

    // Load a full bank of base+n words back-to-back; push the expected kernels.
    task automatic load_full(input logic [31:0] base, input logic rel_last);
        logic [31:0] d;
        for (int n = 0; n < TOTAL; n++) begin
            d = base + 32'(n);
            load_word(n, d, d[3:0], rel_last && (n == TOTAL - 1));
        end
        for (int k = 0; k < NK; k++) exp_q.push_back(model_mem[model_fill][k]);
    endtask

    // Pop expected kernels and compare against the presented weights.
    task automatic check_weights(input string tag);
        logic [35:0] exp_w;
        for (int k = 0; k < NK; k++) begin
            kernel_index = 1'(k);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s_k%0d: scoreboard empty, got %h", tag, k, weights);
            end else begin
                exp_w = exp_q.pop_front();
                if (weights !== exp_w) begin
                    errors++;
                    $display("FAIL %s_k%0d: got %h expected %h", tag, k, weights, exp_w);
                end
            end
        end
        kernel_index = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", weights_valid); end
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL rst_active: got %b expected 0", active_bank); end
        checks++; if (fill_count !== 5'd0) begin errors++; $display("FAIL rst_fill: got %0d expected 0", fill_count); end
        checks++; if (weights !== 36'h0) begin errors++; $display("FAIL rst_weights: got %h expected 0", weights); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", data_ready); end
        model_fill = 1'b0;
    endtask

    task automatic test_first_fill();
        load_full(32'd0, 1'b0);
        checks++; if (weights_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", weights_valid); end
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL first_active: got %b expected 0", active_bank); end
        checks++; if (fill_count !== 5'd0) begin errors++; $display("FAIL first_fill: got %0d expected 0", fill_count); end
        kernel_index = 1'b0; #1;
        checks++; if (weights !== 36'h876543210) begin errors++; $display("FAIL first_k0_const: got %h expected 876543210", weights); end
        kernel_index = 1'b1; #1;
        checks++; if (weights !== 36'h10FEDCBA9) begin errors++; $display("FAIL first_k1_const: got %h expected 10fedcba9", weights); end
        check_weights("first");
        model_fill = 1'b1;
    endtask

    task automatic test_wait_swap();
        load_full(32'h25, 1'b0);
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL wait_ready: got %b expected 0", data_ready); end
        checks++; if (fill_count !== 5'd18) begin errors++; $display("FAIL wait_fill: got %0d expected 18", fill_count); end
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL wait_active: got %b expected 0", active_bank); end
        data_in = 32'h0000000F;
        data_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        data_valid = 1'b0;
        checks++; if (fill_count !== 5'd18) begin errors++; $display("FAIL wait_hold_fill: got %0d expected 18", fill_count); end
        kernel_index = 1'b0; #1;
        checks++; if (weights !== 36'h876543210) begin errors++; $display("FAIL wait_old_bank: got %h expected 876543210", weights); end
        weights_release = 1'b1;
        @(posedge clk);
        #1;
        weights_release = 1'b0;
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL swap_active: got %b expected 1", active_bank); end
        checks++; if (weights_valid !== 1'b1) begin errors++; $display("FAIL swap_valid: got %b expected 1", weights_valid); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL swap_ready: got %b expected 1", data_ready); end
        checks++; if (fill_count !== 5'd0) begin errors++; $display("FAIL swap_fill: got %0d expected 0", fill_count); end
        check_weights("swap");
        model_fill = 1'b0;
    endtask

    task automatic test_release_same_cycle();
        load_full(32'h3A, 1'b1);
        checks++; if (weights_valid !== 1'b1) begin errors++; $display("FAIL same_valid: got %b expected 1", weights_valid); end
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL same_active: got %b expected 0", active_bank); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b expected 1", data_ready); end
        check_weights("same");
        model_fill = 1'b1;
    endtask

    task automatic test_release_drop();
        weights_release = 1'b1;
        @(posedge clk);
        #1;
        weights_release = 1'b0;
        checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b expected 0", weights_valid); end
        for (int k = 0; k < NK; k++) exp_q.push_back(36'h0);
        check_weights("drop");
        weights_release = 1'b1;
        @(posedge clk);
        #1;
        weights_release = 1'b0;
        checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL drop2_valid: got %b expected 0", weights_valid); end
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL drop2_active: got %b expected 0", active_bank); end
    endtask

    task automatic test_clear_reset();
        logic [31:0] d;
        load_full(32'h07, 1'b0);
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL refill_active: got %b expected 1", active_bank); end
        checks++; if (weights_valid !== 1'b1) begin errors++; $display("FAIL refill_valid: got %b expected 1", weights_valid); end
        check_weights("refill");
        model_fill = 1'b0;
        for (int n = 0; n < 7; n++) begin
            d = 32'h41 + 32'(n);
            load_word(n, d, d[3:0], 1'b0);
        end
        checks++; if (fill_count !== 5'd7) begin errors++; $display("FAIL mid_fill: got %0d expected 7", fill_count); end
        data_in = 32'h1; data_valid = 1'b1; clear = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0; clear = 1'b0;
        checks++; if (fill_count !== 5'd0) begin errors++; $display("FAIL clear_fill: got %0d expected 0", fill_count); end
        checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b expected 0", weights_valid); end
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL clear_active: got %b expected 1", active_bank); end
        model_fill = 1'b0;
        load_full(32'h52, 1'b0);
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL post_clear_active: got %b expected 0", active_bank); end
        check_weights("post_clear");
        model_fill = 1'b1;
        load_full(32'h63, 1'b1);
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL pre_rst_active: got %b expected 1", active_bank); end
        check_weights("pre_rst");
        model_fill = 1'b0;
        for (int n = 0; n < 4; n++) begin
            d = 32'h70 + 32'(n);
            load_word(n, d, d[3:0], 1'b0);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", weights_valid); end
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL async_active: got %b expected 0", active_bank); end
        checks++; if (fill_count !== 5'd0) begin errors++; $display("FAIL async_fill: got %0d expected 0", fill_count); end
        checks++; if (weights !== 36'h0) begin errors++; $display("FAIL async_weights: got %h expected 0", weights); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %b expected 1", data_ready); end
        model_fill = 1'b0;
    endtask

    task automatic test_saturation();
        logic [3:0] n0;
        logic [3:0] n1;
`ifdef WEIGHT_BUFFER_SAT_EN
        n0 = 4'h7; n1 = 4'h8;
`else
        n0 = 4'h9; n1 = 4'h0;
`endif
        load_word(0, 32'h00000009, n0, 1'b0);
        load_word(1, 32'hFFFFFFF0, n1, 1'b0);
        for (int n = 2; n < TOTAL; n++) load_word(n, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < NK; k++) exp_q.push_back(model_mem[model_fill][k]);
        checks++; if (weights_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b expected 1", weights_valid); end
        kernel_index = 1'b0; #1;
        checks++; if (weights[7:0] !== {n1, n0}) begin errors++; $display("FAIL sat_nibbles: got %h expected %h", weights[7:0], {n1, n0}); end
        check_weights("sat");
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_wait_swap();
        test_release_same_cycle();
        test_release_drop();
        test_clear_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
